// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, drives a single-outstanding req/ready instruction port,
// and presents instr/pc/pc+4 to the IF/ID register, substituting a NOP when nothing valid is ready.
module instr_fetch_unit #(
    parameter int                 WIDTH     = 32,
    parameter logic [WIDTH-1:0]   RESET_PC  = 32'h0000_0000,
    parameter logic [WIDTH-1:0]   NOP_INSTR = 32'h0000_0013
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_f,
    input  logic             redirect_e,
    input  logic [WIDTH-1:0] target_e,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ready,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] instr_f,
    output logic [WIDTH-1:0] pc_f,
    output logic [WIDTH-1:0] pc_plus4_f,
    output logic             fetch_valid,
    output logic             fetch_busy
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_HOLD  = 2'd1;
    localparam logic [1:0] S_DROP  = 2'd2;

    localparam logic [WIDTH-1:0] PC_STEP    = WIDTH'(4);
    localparam logic [WIDTH-1:0] ALIGN_MASK = {{(WIDTH-2){1'b1}}, 2'b00};

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_hold_instr;
    logic [WIDTH-1:0] r_redir_pc;

    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] w_pc_nxt;
    logic [WIDTH-1:0] w_hold_nxt;
    logic [WIDTH-1:0] w_redir_nxt;

    // Redirect targets are word-aligned by clearing the two low bits.
    function automatic logic [WIDTH-1:0] align_pc(input logic [WIDTH-1:0] addr);
        return addr & ALIGN_MASK;
    endfunction

    // Next-state, next-PC and capture-register selection.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_hold_nxt  = r_hold_instr;
        w_redir_nxt = r_redir_pc;
        case (r_state)
            S_FETCH: begin
                if (imem_ready) begin
                    if (redirect_e) begin
                        w_pc_nxt = align_pc(target_e);
                    end else if (!stall_f) begin
                        w_pc_nxt = r_pc + PC_STEP;
                    end else begin
                        w_hold_nxt  = imem_rdata;
                        w_state_nxt = S_HOLD;
                    end
                end else begin
                    if (redirect_e) begin
                        w_redir_nxt = align_pc(target_e);
                        w_state_nxt = S_DROP;
                    end else begin
                        w_state_nxt = S_FETCH;
                    end
                end
            end
            S_HOLD: begin
                if (redirect_e) begin
                    w_pc_nxt    = align_pc(target_e);
                    w_state_nxt = S_FETCH;
                end else if (!stall_f) begin
                    w_pc_nxt    = r_pc + PC_STEP;
                    w_state_nxt = S_FETCH;
                end else begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_DROP: begin
                // The stale response is consumed here; the newest redirect target wins.
                if (redirect_e) begin
                    w_redir_nxt = align_pc(target_e);
                end else begin
                    w_redir_nxt = r_redir_pc;
                end
                if (imem_ready) begin
                    w_pc_nxt    = redirect_e ? align_pc(target_e) : r_redir_pc;
                    w_state_nxt = S_FETCH;
                end else begin
                    w_state_nxt = S_DROP;
                end
            end
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
    end

    // State and PC registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_FETCH;
            r_pc         <= RESET_PC;
            r_hold_instr <= NOP_INSTR;
            r_redir_pc   <= {WIDTH{1'b0}};
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_hold_instr <= w_hold_nxt;
            r_redir_pc   <= w_redir_nxt;
        end
    end

    // Memory handshake and IF/ID-facing outputs; reset forces the idle bubble.
    always_comb begin
        imem_req    = 1'b0;
        fetch_valid = 1'b0;
        fetch_busy  = 1'b0;
        instr_f     = NOP_INSTR;
        if (rst) begin
            imem_req    = 1'b0;
            fetch_valid = 1'b0;
            fetch_busy  = 1'b0;
            instr_f     = NOP_INSTR;
        end else begin
            case (r_state)
                S_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ready && !redirect_e) begin
                        fetch_valid = 1'b1;
                        instr_f     = imem_rdata;
                    end else if (!imem_ready) begin
                        fetch_busy = 1'b1;
                    end else begin
                        fetch_valid = 1'b0;
                    end
                end
                S_HOLD: begin
                    fetch_valid = 1'b1;
                    instr_f     = r_hold_instr;
                end
                S_DROP: begin
                    imem_req   = 1'b1;
                    fetch_busy = 1'b1;
                end
                default: begin
                    imem_req = 1'b0;
                end
            endcase
        end
    end

    assign imem_addr  = r_pc;
    assign pc_f       = r_pc;
    assign pc_plus4_f = r_pc + PC_STEP;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the IF/ID pipeline register.
- Owns the PC register and next-PC selection: sequential PC+4, or the redirect target from EX on a taken branch or jump.
- Drives a single-outstanding req/ready instruction-memory port. Presents instr_f, pc_f and pc_plus4_f for the IF/ID register to capture when stall_f is low.
- Emits a NOP bubble whenever no valid instruction is available.

Parameters:
- WIDTH, 32, datapath and address width.
- RESET_PC, 0, PC value loaded on reset.
- NOP_INSTR, 32'h00000013, instruction presented when fetch_valid is 0 (addi x0,x0,0).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- stall_f  in  1  hazard-unit stall; the fetched instruction must not advance.
- redirect_e  in  1  taken branch or jump resolved in EX.
- target_e  in  WIDTH  redirect target PC.
- imem_req  out  1  memory request; held high until imem_ready.
- imem_addr  out  WIDTH  request address; stable while imem_req is high.
- imem_ready  in  1  response strobe; imem_rdata is valid in the same cycle when imem_req is high.
- imem_rdata  in  WIDTH  instruction word.
- instr_f  out  WIDTH  instruction to IF/ID (NOP_INSTR when not valid).
- pc_f  out  WIDTH  PC of instr_f.
- pc_plus4_f  out  WIDTH  pc_f+4.
- fetch_valid  out  1  instr_f is a real fetched instruction.
- fetch_busy  out  1  an outstanding request is waiting on memory (FETCH without ready, or DROP).

Behaviour:
- Registers:
  - pc_q: reset RESET_PC.
  - state: reset FETCH.
  - hold_instr: reset NOP_INSTR.
  - redir_pc: reset 0.
- While rst is high:
  - imem_req=0, fetch_valid=0, fetch_busy=0.
  - instr_f=NOP_INSTR, pc_f=RESET_PC, pc_plus4_f=RESET_PC+4.
- All PC arithmetic is modulo 2^WIDTH (0xFFFFFFFC+4 wraps to 0).
- Target bits [1:0] are forced to 0 on load.
- pc_f=pc_q and pc_plus4_f=pc_q+4 in all states.
- State FETCH:
  - imem_req=1, imem_addr=pc_q.
  - ready=1, redirect_e=1: discard rdata; pc_q<=target_e; stay FETCH; fetch_valid=0.
  - ready=1, redirect_e=0, stall_f=0: fetch_valid=1, instr_f=imem_rdata (combinational, zero added latency); pc_q<=pc_q+4; stay FETCH.
  - ready=1, redirect_e=0, stall_f=1: fetch_valid=1, instr_f=imem_rdata; hold_instr<=imem_rdata; go HOLD.
  - ready=0, redirect_e=1: redir_pc<=target_e; go DROP; fetch_valid=0.
  - ready=0, redirect_e=0: fetch_valid=0, instr_f=NOP_INSTR, fetch_busy=1.
- State HOLD:
  - imem_req=0, fetch_valid=1, instr_f=hold_instr.
  - redirect_e=1: pc_q<=target_e; go FETCH (held instruction discarded; redirect beats stall).
  - stall_f=0: pc_q<=pc_q+4; go FETCH.
  - Otherwise remain in HOLD.
- State DROP (stale request in flight):
  - imem_req=1, imem_addr=pc_q unchanged, fetch_valid=0, fetch_busy=1.
  - redirect_e=1 overwrites redir_pc with the newest target.
  - On imem_ready: discard rdata; pc_q<=(redirect_e ? target_e : redir_pc); go FETCH.
- Priority everywhere: rst > redirect_e > stall_f.
- Asserting rst mid-request abandons the transaction. The memory shares rst and drops its pending request.
- The first request after reset release is issued in the same cycle to RESET_PC.
- A single-cycle memory (ready whenever req is high) with no stalls or redirects gives one instruction per cycle.

Test Plan:
- Reset release, ready tied high, no stall: instr_f/pc_f sequence 0x0,0x4,0x8,0xC on consecutive cycles, fetch_valid=1 every cycle.
- Ready low for 3 cycles on PC 0x8: instr_f=0x00000013, fetch_valid=0, fetch_busy=1 for 3 cycles, imem_addr=0x8 stable throughout. Word then delivered with pc_f=0x8.
- stall_f high 2 cycles while word 0xDEADBEEF returns at PC 0x10: instr_f holds 0xDEADBEEF, imem_req=0, pc_f=0x10. After stall drops, next request is to 0x14.
- redirect_e with target 0x103 while a request to 0x20 is pending: enters DROP, imem_addr stays 0x20. Response is discarded, next request goes to 0x100, and no fetch_valid is produced for 0x20.
- redirect_e and stall_f together in HOLD: held instruction dropped, next request goes to the target.
- pc_q=0xFFFFFFFC fetch with no stall: next imem_addr=0x0. Then assert rst mid-request: imem_req=0 immediately, and on release the request goes to RESET_PC.
